lcd_bus_sequencer: RTL and testbench
====================================

# lcd_bus_sequencer

Byte-level write engine for the HD44780-compatible character LCD on the safe's front panel. It is started by `main_controller` through `lcd_enable` and `lcd_cnt`, and picks each byte from the init constant ROM, the cursor-address byte or the refresh data word. It drives the LCD bus pins with 1 ms-granular setup, enable-pulse and hold phases, then reports completion on `lcd_finish`.

## Interface
- `POWERON_MS`, default 40: clk_1ms cycles after reset before the first transfer may start.
- `CLEAR_WAIT_MS`, default 2: extra wait cycles after a 0x01 (clear display) byte.
- `clk_1ms`  in  1  1 kHz system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `lcd_enable`  in  1  run request, active-low; a transfer starts on its 1→0 transition.
- `lcd_cnt`  in  2  number of bytes minus 1 (1–4 bytes).
- `mode`  in  1  1 = init constants (LCD_INIT), 0 = refresh (LCD_REF).
- `DB_sel`  in  1  0 = send `addr_byte`, 1 = send a ROM or data byte.
- `data_sel`  in  1  1 = bytes come from `data_word`.
- `reg_sel`  in  1  value driven on LCD_RS for the whole transfer.
- `addr_byte`  in  8  DDRAM address command (0x80 | position).
- `data_word`  in  32  four display characters, byte 0 = bits [31:24].
- `lcd_finish`  out  1  one-cycle pulse when the last byte's hold or wait phase ends.
- `LCD_E`, `LCD_RS`, `LCD_RW`  out  1 each  LCD control pins; `LCD_RW` is tied to 0.
- `LCD_DB`  out  8  LCD data bus.

## Operation
- Start detect: register `lcd_enable` as `en_q`. `start = en_q & ~lcd_enable & (state==IDLE)`. A low level held after `lcd_finish` never restarts the engine; `lcd_enable` must return high first.
- At start, latch `lcd_cnt`, `mode`, `DB_sel`, `data_sel`, `reg_sel`, `addr_byte` and `data_word`. Input changes during a transfer are ignored. `main_controller` drops `mode` one cycle after start, so latching is required.
- Byte select, using latched values and byte index i (0..cnt):
  - DB_sel=0 → addr_byte.
  - otherwise data_sel=1 → data_word byte i, MSB first.
  - otherwise mode=1 → ROM[i] = 0x38, 0x0C, 0x06, 0x01.
  - otherwise → 0x20.
- States:
  - PWR: count POWERON_MS, then go to IDLE.
  - IDLE: on start, go to SETUP.
  - SETUP: RS and DB valid, E=0.
  - PULSE: E=1.
  - HOLD: E=0, RS and DB held. Go to WAIT if the byte was 0x01, else to NEXT.
  - WAIT: CLEAR_WAIT_MS cycles.
  - NEXT: if i==cnt, go to DONE; else increment i and go to SETUP.
  - DONE: `lcd_finish`=1 for one cycle, then go to IDLE.
- A start edge arriving during PWR or a busy state is dropped, not queued.
- Reset mid-transfer aborts immediately: E low, PWR restarts, and no `lcd_finish` is issued.

## Timing
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DB=0x00, lcd_finish=0, state=PWR, i=0.
- A start edge seen at clock edge k puts the machine in SETUP from edge k+1.
- Per byte: SETUP 1 + PULSE 1 + HOLD 1 = 3 cycles, plus CLEAR_WAIT_MS cycles after 0x01.
- NEXT and DONE take 1 cycle each.
- Latency from start to `lcd_finish` high = 1 + 4·(cnt+1) − 1 + 1 cycles, plus any clear waits. For cnt=3 without a clear byte, that is 17 cycles. The init sequence takes 19 cycles.
- LCD_DB and LCD_RS change only when entering SETUP (or on reset), so they are stable ≥1 ms around each E pulse.
- Outputs are registered; there are no combinational paths from inputs to pins.

## Structure
- `lcd_pkg` holds:
  - the state encoding;
  - the `INIT_ROM` constants 0x38/0x0C/0x06/0x01 and `CLEAR_CMD`=0x01;
  - `LCD_INIT`=1 and `LCD_REF`=0, shared with `main_controller`.
- One sub-module, `lcd_byte_mux`: combinational byte select from the latched controls and i.
- Timer: one 6-bit down counter shared by PWR and WAIT.

## Test plan
- Power-up: pulse reset, then drive `lcd_enable` 1→0 at cycle 10 → no E pulse. After cycle 40, an edge starts a transfer.
- Init: mode=1, DB_sel=1, data_sel=0, cnt=3 → DB sequence 0x38, 0x0C, 0x06, 0x01 with one E pulse each. Two wait cycles follow 0x01, and `lcd_finish` pulses 19 cycles after start.
- Address: DB_sel=0, addr_byte=0x85, cnt=0, reg_sel=0 → one E pulse with DB=0x85 and RS=0, then `lcd_finish` at start+5.
- Refresh: data_sel=1, reg_sel=1, data_word=0x31323334, mode toggled to 1 one cycle after start → DB 0x31, 0x32, 0x33, 0x34 with RS=1. The finish pulse arrives at +17 and the toggle of `mode` has no effect.
- Held low: keep `lcd_enable` low for 30 cycles after `lcd_finish` → no new transfer. Driving it high then low starts the next transfer.
- Reset abort: assert reset during the third byte's PULSE → E=0 and DB=0x00 immediately, no `lcd_finish`, and the 40-cycle power-on wait restarts.

Source files
------------

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the front-panel character LCD write path:
//   - lcd_state_t   : sequencer state encoding
//   - INIT_ROM      : HD44780 init bytes (function set, display on,
//                     entry mode, clear display)
//   - CLEAR_CMD     : clear-display command, which needs an extra wait
//   - LCD_INIT/REF  : mode encoding shared with main_controller
// ---------------------------------------------------------------------------
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWR   = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SETUP = 3'd2,
      ST_PULSE = 3'd3,
      ST_HOLD  = 3'd4,
      ST_WAIT  = 3'd5,
      ST_NEXT  = 3'd6,
      ST_DONE  = 3'd7
   } lcd_state_t;

   localparam logic LCD_INIT = 1'b1;
   localparam logic LCD_REF  = 1'b0;

   localparam logic [7:0] CLEAR_CMD  = 8'h01;
   localparam logic [7:0] BLANK_CHAR = 8'h20;

   localparam logic [7:0] INIT_ROM [0:3] = '{8'h38, 8'h0C, 8'h06, 8'h01};

   // Init constant for byte position idx
   function automatic logic [7:0] init_rom_byte(input logic [1:0] idx);
      return INIT_ROM[idx];
   endfunction

endpackage

// File: rtl/lcd_byte_mux.sv
// ---------------------------------------------------------------------------
// lcd_byte_mux
// Combinational selection of the byte to place on the LCD bus for byte
// index idx, driven from the controls latched at transfer start.
// Ports:
//   db_sel     in   0 = address byte, 1 = ROM/data byte
//   data_sel   in   1 = take byte from data_word
//   mode       in   LCD_INIT = init ROM, LCD_REF = blank fill
//   addr_byte  in   DDRAM address command
//   data_word  in   four characters, byte 0 in bits [31:24]
//   idx        in   byte index 0..3
//   byte_out   out  selected byte
// ---------------------------------------------------------------------------
module lcd_byte_mux
   import lcd_pkg::*;
(
   input  logic        db_sel,
   input  logic        data_sel,
   input  logic        mode,
   input  logic [7:0]  addr_byte,
   input  logic [31:0] data_word,
   input  logic [1:0]  idx,
   output logic [7:0]  byte_out
);

   // Priority select: address, then data word, then init ROM, else blank
   always_comb begin
      byte_out = BLANK_CHAR;
      if (!db_sel) begin
         byte_out = addr_byte;
      end else if (data_sel) begin
         case (idx)
            2'd0:    byte_out = data_word[31:24];
            2'd1:    byte_out = data_word[23:16];
            2'd2:    byte_out = data_word[15:8];
            2'd3:    byte_out = data_word[7:0];
            default: byte_out = BLANK_CHAR;
         endcase
      end else if (mode == LCD_INIT) begin
         byte_out = init_rom_byte(idx);
      end else begin
         byte_out = BLANK_CHAR;
      end
   end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_bus_sequencer
// Byte-level write engine for the HD44780 panel. After a power-on wait,
// each falling edge of lcd_enable (seen while idle) sends 1..4 bytes, each
// as SETUP / E-PULSE / HOLD phases of one 1 ms tick, with an extra wait
// after a clear-display byte, then pulses lcd_finish.
// Ports:
//   clk_1ms     in   1 kHz clock
//   reset       in   asynchronous active-high reset
//   lcd_enable  in   active-low run request (falling edge starts)
//   lcd_cnt     in   byte count minus one
//   mode        in   LCD_INIT / LCD_REF
//   DB_sel      in   0 = address byte, 1 = ROM/data byte
//   data_sel    in   1 = bytes from data_word
//   reg_sel     in   RS level for the whole transfer
//   addr_byte   in   DDRAM address command
//   data_word   in   four characters, MSB byte first
//   lcd_finish  out  one-cycle completion pulse
//   LCD_E/RS/RW out  LCD control pins (RW tied low)
//   LCD_DB      out  LCD data bus
// ---------------------------------------------------------------------------
module lcd_bus_sequencer
   import lcd_pkg::*;
#(
   parameter int POWERON_MS    = 40,
   parameter int CLEAR_WAIT_MS = 2
)
(
   input  logic        clk_1ms,
   input  logic        reset,
   input  logic        lcd_enable,
   input  logic [1:0]  lcd_cnt,
   input  logic        mode,
   input  logic        DB_sel,
   input  logic        data_sel,
   input  logic        reg_sel,
   input  logic [7:0]  addr_byte,
   input  logic [31:0] data_word,
   output logic        lcd_finish,
   output logic        LCD_E,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic [7:0]  LCD_DB
);

   localparam logic [5:0] PWR_LOAD   = 6'(POWERON_MS - 1);
   localparam logic [5:0] CLEAR_LOAD = 6'(CLEAR_WAIT_MS - 1);

   lcd_state_t  state_r;
   logic [5:0]  timer_r;
   logic [1:0]  idx_r;
   logic        en_q;
   logic        start_r;

   logic [1:0]  cnt_r;
   logic        mode_r;
   logic        db_sel_r;
   logic        data_sel_r;
   logic        reg_sel_r;
   logic [7:0]  addr_r;
   logic [31:0] data_r;

   logic        start_s;
   logic [1:0]  idx_sel_s;
   logic [7:0]  byte_s;

   assign LCD_RW  = 1'b0;
   assign start_s = en_q & ~lcd_enable & (state_r == ST_IDLE);

   // In NEXT the bus is reloaded with the following byte, so look one ahead
   always_comb begin
      idx_sel_s = idx_r;
      if (state_r == ST_NEXT) begin
         idx_sel_s = idx_r + 2'd1;
      end else begin
         idx_sel_s = idx_r;
      end
   end

   lcd_byte_mux u_byte_mux (
      .db_sel    (db_sel_r),
      .data_sel  (data_sel_r),
      .mode      (mode_r),
      .addr_byte (addr_r),
      .data_word (data_r),
      .idx       (idx_sel_s),
      .byte_out  (byte_s)
   );

   // Start detection, control latching, phase sequencing and pin drive
   always_ff @(posedge clk_1ms or posedge reset) begin
      if (reset) begin
         state_r    <= ST_PWR;
         timer_r    <= PWR_LOAD;
         idx_r      <= 2'd0;
         en_q       <= 1'b0;
         start_r    <= 1'b0;
         cnt_r      <= 2'd0;
         mode_r     <= 1'b0;
         db_sel_r   <= 1'b0;
         data_sel_r <= 1'b0;
         reg_sel_r  <= 1'b0;
         addr_r     <= 8'h00;
         data_r     <= 32'h0000_0000;
         lcd_finish <= 1'b0;
         LCD_E      <= 1'b0;
         LCD_RS     <= 1'b0;
         LCD_DB     <= 8'h00;
      end else begin
         en_q       <= lcd_enable;
         start_r    <= start_s;
         lcd_finish <= 1'b0;
         case (state_r)
            ST_PWR: begin
               if (timer_r == 6'd0) begin
                  state_r <= ST_IDLE;
               end else begin
                  timer_r <= timer_r - 6'd1;
               end
            end
            ST_IDLE: begin
               // Controls are captured on the start edge itself because
               // main_controller changes mode on the very next cycle.
               if (start_s) begin
                  cnt_r      <= lcd_cnt;
                  mode_r     <= mode;
                  db_sel_r   <= DB_sel;
                  data_sel_r <= data_sel;
                  reg_sel_r  <= reg_sel;
                  addr_r     <= addr_byte;
                  data_r     <= data_word;
                  idx_r      <= 2'd0;
               end else if (start_r) begin
                  state_r <= ST_SETUP;
                  LCD_RS  <= reg_sel_r;
                  LCD_DB  <= byte_s;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               LCD_E   <= 1'b1;
               state_r <= ST_PULSE;
            end
            ST_PULSE: begin
               LCD_E   <= 1'b0;
               state_r <= ST_HOLD;
            end
            ST_HOLD: begin
               if (LCD_DB == CLEAR_CMD) begin
                  timer_r <= CLEAR_LOAD;
                  state_r <= ST_WAIT;
               end else begin
                  state_r <= ST_NEXT;
               end
            end
            ST_WAIT: begin
               if (timer_r == 6'd0) begin
                  state_r <= ST_NEXT;
               end else begin
                  timer_r <= timer_r - 6'd1;
               end
            end
            ST_NEXT: begin
               if (idx_r == cnt_r) begin
                  lcd_finish <= 1'b1;
                  state_r    <= ST_DONE;
               end else begin
                  idx_r   <= idx_r + 2'd1;
                  LCD_DB  <= byte_s;
                  state_r <= ST_SETUP;
               end
            end
            ST_DONE: begin
               idx_r   <= 2'd0;
               state_r <= ST_IDLE;
            end
            default: begin
               LCD_E   <= 1'b0;
               timer_r <= PWR_LOAD;
               state_r <= ST_PWR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_sequencer
// Self-checking bench for lcd_bus_sequencer. Expected {RS,DB} bytes are
// queued when a transfer is requested; bytes seen on each rising LCD_E are
// queued as observed and compared in order, along with finish latency.
// ---------------------------------------------------------------------------
module tb_lcd_bus_sequencer;

   logic        clk_1ms = 1'b0;
   logic        reset = 1'b0;
   logic        lcd_enable = 1'b1;
   logic [1:0]  lcd_cnt = 2'd0;
   logic        mode = 1'b0;
   logic        DB_sel = 1'b0;
   logic        data_sel = 1'b0;
   logic        reg_sel = 1'b0;
   logic [7:0]  addr_byte = 8'h00;
   logic [31:0] data_word = 32'h0000_0000;
   logic        lcd_finish;
   logic        LCD_E;
   logic        LCD_RS;
   logic        LCD_RW;
   logic [7:0]  LCD_DB;

   int checks = 0;
   int errors = 0;

   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];

   always #5 clk_1ms = ~clk_1ms;

   lcd_bus_sequencer dut (
      .clk_1ms    (clk_1ms),
      .reset      (reset),
      .lcd_enable (lcd_enable),
      .lcd_cnt    (lcd_cnt),
      .mode       (mode),
      .DB_sel     (DB_sel),
      .data_sel   (data_sel),
      .reg_sel    (reg_sel),
      .addr_byte  (addr_byte),
      .data_word  (data_word),
      .lcd_finish (lcd_finish),
      .LCD_E      (LCD_E),
      .LCD_RS     (LCD_RS),
      .LCD_RW     (LCD_RW),
      .LCD_DB     (LCD_DB)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk_1ms);
      #1;
   endtask

   // Runs up to budget cycles, recording {RS,DB} at each E rise; fin is the
   // cycle index (counted from first_c) at which lcd_finish is seen, or -1.
   task automatic collect(input int budget, input int first_c,
                          output int fin, output int pulses);
      logic pe;
      pe     = LCD_E;
      fin    = -1;
      pulses = 0;
      obs_q.delete();
      for (int n = 0; n < budget; n++) begin
         tick(1);
         if (LCD_E && !pe) begin
            pulses++;
            obs_q.push_back({LCD_RS, LCD_DB});
         end
         pe = LCD_E;
         if (lcd_finish) begin
            fin = first_c + n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      tick(3);
      checks++;
      if (LCD_E !== 1'b0) begin errors++; $display("FAIL reset_E got %b want 0", LCD_E); end
      checks++;
      if (LCD_RS !== 1'b0) begin errors++; $display("FAIL reset_RS got %b want 0", LCD_RS); end
      checks++;
      if (LCD_RW !== 1'b0) begin errors++; $display("FAIL reset_RW got %b want 0", LCD_RW); end
      checks++;
      if (LCD_DB !== 8'h00) begin errors++; $display("FAIL reset_DB got %h want 00", LCD_DB); end
      checks++;
      if (lcd_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", lcd_finish); end
      reset = 1'b0;
   endtask

   // Starts during the power-on wait (including the last PWR cycle) are dropped
   task automatic test_power_up();
      int e_seen;
      int f_seen;
      e_seen = 0;
      f_seen = 0;
      tick(9);
      lcd_enable = 1'b0;
      for (int n = 0; n < 20; n++) begin
         tick(1);
         if (LCD_E) e_seen++;
         if (lcd_finish) f_seen++;
      end
      lcd_enable = 1'b1;
      for (int n = 0; n < 10; n++) begin
         tick(1);
         if (LCD_E) e_seen++;
         if (lcd_finish) f_seen++;
      end
      lcd_enable = 1'b0;
      for (int n = 0; n < 21; n++) begin
         tick(1);
         if (LCD_E) e_seen++;
         if (lcd_finish) f_seen++;
      end
      checks++;
      if (e_seen !== 0) begin errors++; $display("FAIL pwr_no_pulse got %0d E cycles want 0", e_seen); end
      checks++;
      if (f_seen !== 0) begin errors++; $display("FAIL pwr_no_finish got %0d want 0", f_seen); end
      lcd_enable = 1'b1;
      tick(1);
   endtask

   task automatic test_init();
      int fin;
      int pulses;
      logic [8:0] e;
      logic [8:0] o;
      lcd_cnt  = 2'd3;
      mode     = 1'b1;
      DB_sel   = 1'b1;
      data_sel = 1'b0;
      reg_sel  = 1'b0;
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h06});
      exp_q.push_back({1'b0, 8'h01});
      lcd_enable = 1'b0;
      collect(40, 0, fin, pulses);
      checks++;
      if (pulses !== 4) begin errors++; $display("FAIL init_pulses got %0d want 4", pulses); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL init_byte got none want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL init_byte got %h want %h", o, e); end
         end
      end
      checks++;
      if (fin !== 19) begin errors++; $display("FAIL init_latency got %0d want 19", fin); end
      mode = 1'b0;
      lcd_enable = 1'b1;
      tick(2);
   endtask

   task automatic test_address();
      int fin;
      int pulses;
      logic [8:0] o;
      lcd_cnt   = 2'd0;
      DB_sel    = 1'b0;
      reg_sel   = 1'b0;
      addr_byte = 8'h85;
      exp_q.push_back({1'b0, 8'h85});
      lcd_enable = 1'b0;
      collect(20, 0, fin, pulses);
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL addr_pulses got %0d want 1", pulses); end
      checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h1FF;
      if (o !== exp_q.pop_front()) begin errors++; $display("FAIL addr_byte got %h want 085", o); end
      checks++;
      if (fin !== 5) begin errors++; $display("FAIL addr_latency got %0d want 5", fin); end
      lcd_enable = 1'b1;
      tick(2);
   endtask

   // Refresh with mode and data_word disturbed right after start
   task automatic test_refresh();
      int fin;
      int pulses;
      logic [8:0] e;
      logic [8:0] o;
      lcd_cnt   = 2'd3;
      mode      = 1'b0;
      DB_sel    = 1'b1;
      data_sel  = 1'b1;
      reg_sel   = 1'b1;
      data_word = 32'h3132_3334;
      exp_q.push_back({1'b1, 8'h31});
      exp_q.push_back({1'b1, 8'h32});
      exp_q.push_back({1'b1, 8'h33});
      exp_q.push_back({1'b1, 8'h34});
      lcd_enable = 1'b0;
      tick(1);
      mode      = 1'b1;
      data_sel  = 1'b0;
      data_word = 32'h4142_4344;
      reg_sel   = 1'b0;
      collect(40, 1, fin, pulses);
      checks++;
      if (pulses !== 4) begin errors++; $display("FAIL ref_pulses got %0d want 4", pulses); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++; $display("FAIL ref_byte got none want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL ref_byte got %h want %h", o, e); end
         end
      end
      checks++;
      if (fin !== 17) begin errors++; $display("FAIL ref_latency got %0d want 17", fin); end
      mode = 1'b0;
   endtask

   // lcd_enable stays low after finish: no restart until it goes high again
   task automatic test_held_low();
      int fin;
      int pulses;
      logic [8:0] o;
      collect(30, 0, fin, pulses);
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL held_pulses got %0d want 0", pulses); end
      checks++;
      if (fin !== -1) begin errors++; $display("FAIL held_finish got %0d want -1", fin); end
      lcd_enable = 1'b1;
      tick(1);
      lcd_cnt   = 2'd0;
      DB_sel    = 1'b0;
      reg_sel   = 1'b0;
      addr_byte = 8'hC3;
      exp_q.push_back({1'b0, 8'hC3});
      lcd_enable = 1'b0;
      collect(20, 0, fin, pulses);
      checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h1FF;
      if (o !== exp_q.pop_front()) begin errors++; $display("FAIL restart_byte got %h want 0c3", o); end
      checks++;
      if (fin !== 5) begin errors++; $display("FAIL restart_latency got %0d want 5", fin); end
      lcd_enable = 1'b1;
      tick(2);
   endtask

   task automatic test_reset_abort();
      int e_seen;
      int f_seen;
      int fin;
      int pulses;
      logic [8:0] o;
      e_seen = 0;
      f_seen = 0;
      lcd_cnt  = 2'd3;
      mode     = 1'b1;
      DB_sel   = 1'b1;
      data_sel = 1'b0;
      reg_sel  = 1'b0;
      lcd_enable = 1'b0;
      tick(11);
      checks++;
      if (LCD_E !== 1'b1 || LCD_DB !== 8'h06) begin
         errors++; $display("FAIL abort_third_pulse got E=%b DB=%h want E=1 DB=06", LCD_E, LCD_DB);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (LCD_E !== 1'b0) begin errors++; $display("FAIL abort_E got %b want 0", LCD_E); end
      checks++;
      if (LCD_DB !== 8'h00) begin errors++; $display("FAIL abort_DB got %h want 00", LCD_DB); end
      tick(2);
      if (lcd_finish) f_seen++;
      reset = 1'b0;
      mode = 1'b0;
      lcd_enable = 1'b1;
      for (int n = 0; n < 39; n++) begin
         tick(1);
         if (LCD_E) e_seen++;
         if (lcd_finish) f_seen++;
      end
      lcd_enable = 1'b0;
      for (int n = 0; n < 10; n++) begin
         tick(1);
         if (LCD_E) e_seen++;
         if (lcd_finish) f_seen++;
      end
      checks++;
      if (e_seen !== 0) begin errors++; $display("FAIL abort_pwr_pulse got %0d E cycles want 0", e_seen); end
      checks++;
      if (f_seen !== 0) begin errors++; $display("FAIL abort_finish got %0d want 0", f_seen); end
      lcd_enable = 1'b1;
      tick(1);
      lcd_cnt   = 2'd0;
      DB_sel    = 1'b0;
      addr_byte = 8'h8F;
      exp_q.push_back({1'b0, 8'h8F});
      lcd_enable = 1'b0;
      collect(20, 0, fin, pulses);
      checks++;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 9'h1FF;
      if (o !== exp_q.pop_front()) begin errors++; $display("FAIL post_abort_byte got %h want 08f", o); end
      checks++;
      if (fin !== 5) begin errors++; $display("FAIL post_abort_latency got %0d want 5", fin); end
      lcd_enable = 1'b1;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_init();
      test_address();
      test_refresh();
      test_held_low();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
